// File: rtl/rat_intc_pkg.sv
// Shared types and default port IDs for the RAT MCU interrupt controller.
package rat_intc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    WAIT   = 2'd2
  } intc_state_e;

  localparam logic [7:0] MASK_ID_DEF   = 8'hE0;
  localparam logic [7:0] ACK_ID_DEF    = 8'hE1;
  localparam logic [7:0] STATUS_ID_DEF = 8'hE2;
  localparam logic [7:0] CAUSE_ID_DEF  = 8'hE3;

  localparam int unsigned CAUSE_VALID  = 7;

endpackage

// File: rtl/rat_intr_ctrl_prio_enc8.sv
// Combinational lowest-set-bit encoder: idx_o is the lowest asserted request, any_o flags any request.
module prio_enc8 (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       any_o
);

  logic found;

  always_comb begin
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (req_i[i] && !found) begin
        idx_o = 3'(i);
        found = 1'b1;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/rat_intr_ctrl.sv
// Interrupt controller for RATMCU.INTR: edge capture, masking, lowest-index priority, timed pulse, ack handshake.
// Optional INTC_SYNC_EN adds a 2-flop synchronizer on IRQ ahead of the edge detector.
module rat_intr_ctrl
  import rat_intc_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned INTR_CYCLES = 2,
  parameter logic [7:0]  MASK_ID     = MASK_ID_DEF,
  parameter logic [7:0]  ACK_ID      = ACK_ID_DEF,
  parameter logic [7:0]  STATUS_ID   = STATUS_ID_DEF,
  parameter logic [7:0]  CAUSE_ID    = CAUSE_ID_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] IRQ,
  input  logic [7:0]         PORT_ID,
  input  logic [7:0]         OUT_PORT,
  input  logic               IO_STRB,
  output logic [7:0]         IN_DATA,
  output logic               IN_HIT,
  output logic               INTR
);

  localparam logic [3:0] CNT_LOAD = 4'(INTR_CYCLES - 1);

  logic [NUM_SRC-1:0] irq_src;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] rise;
  logic [7:0]         pend8;
  logic [2:0]         sel_idx;
  logic               any_pend;
  logic               wr_mask, wr_ack;

  intc_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        intr_q, intr_d;
  logic [7:0]  cause_q, cause_d;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= IRQ;
      sync2_q <= sync1_q;
    end
  end

  always_comb irq_src = sync2_q;
`else
  always_comb irq_src = IRQ;
`endif

  always_comb begin
    wr_mask = IO_STRB && (PORT_ID == MASK_ID);
    wr_ack  = IO_STRB && (PORT_ID == ACK_ID);
    rise    = irq_src & ~irq_q & mask_q;
    // A new edge is OR-ed in after the ack clear so a coincident set survives.
    pend_d  = pend_q;
    if (wr_ack) pend_d = pend_d & ~OUT_PORT[NUM_SRC-1:0];
    pend_d  = pend_d | rise;
    mask_d  = wr_mask ? OUT_PORT[NUM_SRC-1:0] : mask_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_q  <= '0;
      mask_q <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= irq_src;
      mask_q <= mask_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    pend8 = '0;
    pend8[NUM_SRC-1:0] = pend_q;
  end

  prio_enc8 u_prio (
    .req_i (pend8),
    .idx_o (sel_idx),
    .any_o (any_pend)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    intr_d  = intr_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          cause_d = {1'b1, 4'b0000, sel_idx};
          cnt_d   = CNT_LOAD;
          intr_d  = 1'b1;
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        if (cnt_q == '0) begin
          intr_d  = 1'b0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WAIT: begin
        if (!pend8[cause_q[2:0]]) begin
          cause_d[CAUSE_VALID] = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        intr_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      intr_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      intr_q  <= intr_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    IN_HIT  = (PORT_ID == STATUS_ID) || (PORT_ID == CAUSE_ID);
    IN_DATA = '0;
    if (PORT_ID == STATUS_ID)     IN_DATA = pend8;
    else if (PORT_ID == CAUSE_ID) IN_DATA = cause_q;
  end

  always_comb INTR = intr_q;

endmodule
